// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks: sizing helper,
// maximal-length LFSR tap masks and dot-product engine state encodings.
package sc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Fibonacci tap masks for widths 4..16; bit k-1 set means stage k feeds back.
  localparam logic [15:0] LFSR_TAPS [4:16] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned n;
    n = 0;
    while ((64'd1 << n) < 64'(value)) n++;
    return n;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR used as a stochastic number source; never
// reaches the all-zero state when seeded nonzero.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  localparam logic [15:0]      TAPS_FULL = LFSR_TAPS[WIDTH];
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= SEED;
    end else if (load) begin
      out <= SEED;
    end else if (enable) begin
      out <= {out[WIDTH-2:0], ^(out & TAPS)};
    end
  end

endmodule

// File: rtl/sc_dot_product_engine.sv
// Stochastic dot-product engine: SNG compares, AND multipliers, MUX adder,
// ones counter and binary rescale under a start/done handshake.
module sc_dot_product_engine
  import sc_pkg::*;
#(
  parameter int unsigned DIMENSION   = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STREAM_LOG2 = WIDTH,
  parameter int unsigned SEED_DATA   = 1,
  parameter int unsigned SEED_WEIGHT = (1 << (WIDTH - 1)) + 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [WIDTH*DIMENSION-1:0]                 datas,
  input  logic [WIDTH*DIMENSION-1:0]                 weights,
  output logic                                       busy,
  output logic                                       done,
  output logic [STREAM_LOG2:0]                       count,
  output logic [2*WIDTH+clogb2(DIMENSION)-1:0]       result
);

  localparam int unsigned SEL_W = clogb2(DIMENSION);
  localparam int unsigned CNT_W = STREAM_LOG2 + 1;
  localparam int unsigned RES_W = 2 * WIDTH + SEL_W;
  localparam int unsigned SHIFT = SEL_W + 2 * WIDTH - STREAM_LOG2;
  localparam logic [CNT_W-1:0] FULL = {1'b1, {STREAM_LOG2{1'b0}}};

  logic [1:0]                   state;
  logic [WIDTH*DIMENSION-1:0]   datas_q, weights_q;
  logic [DIMENSION-1:0]         s_d, s_w, s_d_next, s_w_next;
  logic                         p;
  logic [CNT_W-1:0]             acc;
  logic [STREAM_LOG2-1:0]       ctr;
  logic [SEL_W-1:0]             sel;
  logic [WIDTH-1:0]             rng_data, rng_weight;
  logic [RES_W-1:0]             result_next;
  logic                         accept, lfsr_en;

  assign accept  = start && (state == ST_IDLE || state == ST_DONE);
  assign lfsr_en = (state == ST_RUN);

  sc_lfsr #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED_DATA))) u_lfsr_data (
    .clk(clk), .rst(rst), .load(accept), .enable(lfsr_en), .out(rng_data)
  );

  sc_lfsr #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED_WEIGHT))) u_lfsr_weight (
    .clk(clk), .rst(rst), .load(accept), .enable(lfsr_en), .out(rng_weight)
  );

  always_comb begin
    s_d_next = '0;
    s_w_next = '0;
    for (int unsigned d = 0; d < DIMENSION; d++) begin
      s_d_next[d] = datas_q[d*WIDTH +: WIDTH] > rng_data;
      s_w_next[d] = weights_q[d*WIDTH +: WIDTH] > rng_weight;
    end
  end

  always_comb begin
    result_next = RES_W'(acc) << SHIFT;
    if (acc == FULL) result_next = '1;
  end

  // Stages are cleared on accept so the first two RUN edges add zero; the two
  // DRAIN edges then absorb the last two samples, giving exactly N ones counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      datas_q   <= '0;
      weights_q <= '0;
      s_d       <= '0;
      s_w       <= '0;
      p         <= 1'b0;
      acc       <= '0;
      ctr       <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            s_d <= s_d_next;
            s_w <= s_w_next;
            p   <= s_d[sel] & s_w[sel];
            acc <= acc + CNT_W'(p);
            sel <= sel + SEL_W'(1);
            ctr <= ctr + STREAM_LOG2'(1);
            if (ctr == '1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            p   <= s_d[sel] & s_w[sel];
            acc <= acc + CNT_W'(p);
            ctr <= ctr + STREAM_LOG2'(1);
            if (ctr[0]) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          count  <= acc;
          result <= result_next;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: ;
      endcase
      // A start in the done cycle overrides the return to IDLE.
      if (accept) begin
        state     <= ST_RUN;
        busy      <= 1'b1;
        datas_q   <= datas;
        weights_q <= weights;
        s_d       <= '0;
        s_w       <= '0;
        p         <= 1'b0;
        acc       <= '0;
        ctr       <= '0;
        sel       <= '0;
      end
    end
  end

endmodule
